// File: rtl/wolfram_lut_pkg.sv
// Shared types and helpers for the Wolfram rule truth-table evaluator.
// Table bit ordering is reversed: input value 0 maps to the MSB of the rule word.
package wolfram_lut_pkg;

  localparam int TT_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Returns the table entry for input value idx in a rule word tt_w bits wide.
  function automatic logic tt_bit(input logic [TT_MAX-1:0] tt, input int tt_w, input int idx);
    logic [5:0] pos;
    pos = 6'(tt_w - 1 - idx);
    return tt[pos];
  endfunction

endpackage

// File: rtl/wolfram_lut_seq.sv
// Registered N-input truth-table evaluator with a runtime-loadable rule word
// and a table sweep that reports the table contents and its popcount.
module wolfram_lut_seq
  import wolfram_lut_pkg::*;
#(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 8'h2C,
  localparam int TT_W = 1 << N_IN,
  localparam int IW = (TT_W > 1) ? $clog2(TT_W) : 1,
  localparam int OW = $clog2(TT_W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  input  logic            in_valid,
  output logic            out,
  output logic            out_valid,
  input  logic [TT_W-1:0] cfg_tt,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [TT_W-1:0] sweep_tt,
  output logic [OW-1:0]   sweep_ones
);

  state_t            state, state_nx;
  logic [TT_W-1:0]   tt_q;
  logic [TT_MAX-1:0] tt_ext;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     rpos;
  logic              run_bit;
  logic              idx_last;

  assign tt_ext   = TT_MAX'(tt_q);
  // TT_W is a power of two, so (TT_W-1-idx) is just the bitwise complement.
  assign rpos     = ~idx;
  assign run_bit  = tt_bit(tt_ext, TT_W, 32'(idx));
  assign idx_last = (idx == IW'(TT_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tt_q <= TT_INIT;
    end else if (cfg_valid && cfg_ready) begin
      tt_q <= cfg_tt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= tt_bit(tt_ext, TT_W, 32'(in));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sweep_start) state_nx = RUN;
      RUN:     if (idx_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = 1'b0;
    sweep_busy = 1'b0;
    sweep_done = 1'b0;
    unique case (state)
      IDLE:    cfg_ready = 1'b1;
      RUN:     sweep_busy = 1'b1;
      DONE:    sweep_done = 1'b1;
      default: cfg_ready = 1'b0;
    endcase
  end

  // idx stops at the last entry rather than wrapping; results hold until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      sweep_tt   <= '0;
      sweep_ones <= '0;
    end else if (state == IDLE && sweep_start) begin
      idx        <= '0;
      sweep_tt   <= '0;
      sweep_ones <= '0;
    end else if (state == RUN) begin
      sweep_tt[rpos] <= run_bit;
      sweep_ones     <= sweep_ones + OW'(run_bit);
      if (!idx_last) begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wolfram_lut_seq.sv
// Scoreboard bench for wolfram_lut_seq: an 8-entry instance (default rule 0x2C)
// and a 16-entry instance (rule 0x8001), with queue-based output monitors.
module tb_wolfram_lut_seq;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  ones;
  } sw_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  in8;
  logic        iv8, out8, ov8, cv8, cr8, ss8, busy8, done8;
  logic [7:0]  cfg_tt8, stt8;
  logic [3:0]  ones8;
  logic [3:0]  in4;
  logic        iv4, out4, ov4, cv4, cr4, ss4, busy4, done4;
  logic [15:0] cfg_tt4, stt4;
  logic [4:0]  ones4;

  int checks = 0;
  int errors = 0;

  logic eq8[$];
  logic eq4[$];
  sw_t  sq8[$];
  sw_t  sq4[$];

  wolfram_lut_seq #(.N_IN(3), .TT_INIT(8'h2C)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .in_valid(iv8), .out(out8), .out_valid(ov8),
    .cfg_tt(cfg_tt8), .cfg_valid(cv8), .cfg_ready(cr8), .sweep_start(ss8),
    .sweep_busy(busy8), .sweep_done(done8), .sweep_tt(stt8), .sweep_ones(ones8)
  );

  wolfram_lut_seq #(.N_IN(4), .TT_INIT(16'h8001)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(iv4), .out(out4), .out_valid(ov4),
    .cfg_tt(cfg_tt4), .cfg_valid(cv4), .cfg_ready(cr4), .sweep_start(ss4),
    .sweep_busy(busy4), .sweep_done(done4), .sweep_tt(stt4), .sweep_ones(ones4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      chk("out8_expected_present", 64'(eq8.size() != 0), 64'd1);
      if (eq8.size() != 0) chk("out8", 64'(out8), 64'(eq8.pop_front()));
    end
    if (ov4 === 1'b1) begin
      chk("out4_expected_present", 64'(eq4.size() != 0), 64'd1);
      if (eq4.size() != 0) chk("out4", 64'(out4), 64'(eq4.pop_front()));
    end
    if (done8 === 1'b1) begin
      chk("sweep8_expected_present", 64'(sq8.size() != 0), 64'd1);
      if (sq8.size() != 0) begin
        sw_t e;
        e = sq8.pop_front();
        chk("sweep_tt8", 64'(stt8), 64'(e.tt));
        chk("sweep_ones8", 64'(ones8), 64'(e.ones));
      end
    end
    if (done4 === 1'b1) begin
      chk("sweep4_expected_present", 64'(sq4.size() != 0), 64'd1);
      if (sq4.size() != 0) begin
        sw_t e;
        e = sq4.pop_front();
        chk("sweep_tt4", 64'(stt4), 64'(e.tt));
        chk("sweep_ones4", 64'(ones4), 64'(e.ones));
      end
    end
  end

  task automatic eval8(input logic [2:0] v, input logic e);
    in8 = v; iv8 = 1'b1; eq8.push_back(e);
    tick();
    iv8 = 1'b0;
  endtask

  task automatic eval4(input logic [3:0] v, input logic e);
    in4 = v; iv4 = 1'b1; eq4.push_back(e);
    tick();
    iv4 = 1'b0;
  endtask

  task automatic do_sweep8(input logic load, input logic [7:0] word,
                           input logic [7:0] exp_tt, input logic [4:0] exp_ones);
    int nbusy, ncyc;
    sq8.push_back('{tt: 16'(exp_tt), ones: exp_ones});
    chk("cfg_ready8_idle", 64'(cr8), 64'd1);
    if (load) begin
      cfg_tt8 = word; cv8 = 1'b1;
    end
    ss8 = 1'b1;
    tick();
    ss8 = 1'b0; cv8 = 1'b0;
    nbusy = 0; ncyc = 1;
    while (done8 !== 1'b1 && ncyc < 40) begin
      if (busy8 === 1'b1) nbusy++;
      tick();
      ncyc++;
    end
    chk("sweep8_busy_cycles", 64'(nbusy), 64'd8);
    chk("sweep8_latency", 64'(ncyc), 64'd9);
    chk("sweep8_busy_in_done", 64'(busy8), 64'd0);
    tick();
    chk("sweep8_done_one_cycle", 64'(done8), 64'd0);
    chk("cfg_ready8_after", 64'(cr8), 64'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, nbusy;
    rst = 1'b1;
    in8 = '0; iv8 = 1'b0; cv8 = 1'b0; ss8 = 1'b0; cfg_tt8 = '0;
    in4 = '0; iv4 = 1'b0; cv4 = 1'b0; ss4 = 1'b0; cfg_tt4 = '0;
    repeat (3) tick();
    chk("reset_out8", 64'(out8), 64'd0);
    chk("reset_ov8", 64'(ov8), 64'd0);
    chk("reset_stt8", 64'(stt8), 64'd0);
    chk("reset_ones8", 64'(ones8), 64'd0);
    chk("reset_done8", 64'(done8), 64'd0);
    chk("reset_busy8", 64'(busy8), 64'd0);
    chk("reset_cfg_ready8", 64'(cr8), 64'd1);
    chk("reset_stt4", 64'(stt4), 64'd0);
    rst = 1'b0;
    tick();

    // Default rule 0x2C: 010, 100, 101 give 1.
    in8 = 3'b010; iv8 = 1'b1; eq8.push_back(1'b1);
    tick();
    iv8 = 1'b0;
    chk("eval8_latency_valid", 64'(ov8), 64'd1);
    chk("eval8_latency_out", 64'(out8), 64'd1);
    tick();
    chk("eval8_valid_drops", 64'(ov8), 64'd0);
    chk("eval8_out_holds", 64'(out8), 64'd1);
    eval8(3'b011, 1'b0);
    eval8(3'b101, 1'b1);
    eval8(3'b100, 1'b1);
    eval8(3'b000, 1'b0);
    eval8(3'b111, 1'b0);

    // Load 0x96; evaluation in the accept cycle still sees 0x2C.
    cfg_tt8 = 8'h96; cv8 = 1'b1;
    in8 = 3'b000; iv8 = 1'b1; eq8.push_back(1'b0);
    tick();
    cv8 = 1'b0; iv8 = 1'b0;
    eval8(3'b000, 1'b1);
    eval8(3'b111, 1'b0);
    eval8(3'b011, 1'b1);
    eval8(3'b101, 1'b1);
    eval8(3'b010, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    do_sweep8(1'b0, 8'h00, 8'h2C, 5'd3);

    // Config stalls during the sweep and is accepted once back in IDLE.
    sq8.push_back('{tt: 16'h002C, ones: 5'd3});
    ss8 = 1'b1;
    tick();
    ss8 = 1'b0;
    cfg_tt8 = 8'hFF; cv8 = 1'b1;
    in8 = 3'b011; iv8 = 1'b1; eq8.push_back(1'b0);
    chk("cfg_ready8_run", 64'(cr8), 64'd0);
    tick();
    iv8 = 1'b0;
    ncyc = 2;
    while (done8 !== 1'b1 && ncyc < 40) begin
      chk("cfg_ready8_stall", 64'(cr8), 64'd0);
      ss8 = (ncyc == 4);
      tick();
      ncyc++;
    end
    ss8 = 1'b0;
    chk("sweep8_latency_stall", 64'(ncyc), 64'd9);
    chk("cfg_ready8_done", 64'(cr8), 64'd0);
    tick();
    chk("cfg_ready8_after_done", 64'(cr8), 64'd1);
    chk("restart_ignored_busy", 64'(busy8), 64'd0);
    in8 = 3'b011; iv8 = 1'b1; eq8.push_back(1'b0);
    tick();
    cv8 = 1'b0; iv8 = 1'b0;
    eval8(3'b011, 1'b1);
    do_sweep8(1'b0, 8'h00, 8'hFF, 5'd8);

    // Load and start together: the sweep reads the new word.
    do_sweep8(1'b1, 8'h96, 8'h96, 5'd4);

    // Reset in the 4th RUN cycle.
    ss8 = 1'b1;
    tick();
    ss8 = 1'b0;
    repeat (3) tick();
    chk("partial_stt8", 64'(stt8), 64'h80);
    chk("partial_busy8", 64'(busy8), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_stt8", 64'(stt8), 64'd0);
    chk("midrst_ones8", 64'(ones8), 64'd0);
    chk("midrst_cfg_ready8", 64'(cr8), 64'd1);
    chk("midrst_busy8", 64'(busy8), 64'd0);
    chk("midrst_done8", 64'(done8), 64'd0);
    repeat (12) tick();
    eval8(3'b011, 1'b0);
    eval8(3'b000, 1'b0);
    eval8(3'b010, 1'b1);

    // 16-entry instance, rule 0x8001.
    eval4(4'b0000, 1'b1);
    eval4(4'b1111, 1'b1);
    eval4(4'b0001, 1'b0);
    eval4(4'b1000, 1'b0);
    sq4.push_back('{tt: 16'h8001, ones: 5'd2});
    ss4 = 1'b1;
    tick();
    ss4 = 1'b0;
    nbusy = 0; ncyc = 1;
    while (done4 !== 1'b1 && ncyc < 60) begin
      if (busy4 === 1'b1) nbusy++;
      tick();
      ncyc++;
    end
    chk("sweep4_busy_cycles", 64'(nbusy), 64'd16);
    chk("sweep4_latency", 64'(ncyc), 64'd17);
    tick();
    chk("cfg_ready4_after", 64'(cr4), 64'd1);

    repeat (3) tick();
    chk("eq8_drained", 64'(eq8.size()), 64'd0);
    chk("eq4_drained", 64'(eq4.size()), 64'd0);
    chk("sq8_drained", 64'(sq8.size()), 64'd0);
    chk("sq4_drained", 64'(sq4.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
